// File: rtl/dac_settle_sequencer_if.sv
// Request and serial-driver bus of the DAC settling sequencer.
// The sequencer uses the slave view; the application plus DAC driver use the master view.
interface dac_settle_sequencer_if #(
    parameter int ChanBits  = 1,
    parameter int DataWidth = 10
);
    logic                 req_valid;
    logic [ChanBits-1:0]  req_channel;
    logic [DataWidth-1:0] req_data;
    logic                 req_ready;
    logic                 drv_trigger;
    logic [ChanBits-1:0]  drv_channel;
    logic [DataWidth-1:0] drv_din;
    logic                 drv_busy;

    modport master (
        output req_valid,
        output req_channel,
        output req_data,
        input  req_ready,
        input  drv_trigger,
        input  drv_channel,
        input  drv_din,
        output drv_busy
    );

    modport slave (
        input  req_valid,
        input  req_channel,
        input  req_data,
        output req_ready,
        output drv_trigger,
        output drv_channel,
        output drv_din,
        input  drv_busy
    );
endinterface

// File: rtl/dac_settle_sequencer.sv
// DAC write sequencer: accepts one request, fires a one-cycle trigger to the
// serial DAC driver, follows the driver's busy line, then waits out the analog
// settling interval before flagging the target channel as settled.
module dac_settle_sequencer #(
    parameter int  ClockFreq    = 50_000_000,
    parameter real SettlingTime = 4.5e-6,
    parameter int  NumChannels  = 2,
    parameter int  DataWidth    = 10,
    parameter int  StartTimeout = 8
) (
    input  logic                   clk_50MHZ,
    input  logic                   clear,
    dac_settle_sequencer_if.slave  bus,
    output logic                   busy,
    output logic [NumChannels-1:0] settled,
    output logic                   timeout_err,
    input  logic                   err_clear
);
    localparam int ChanBits     = $clog2(NumChannels);
    // Rounded to the nearest whole clock; the product is always non-negative.
    localparam int SettleClocks = $rtoi(ClockFreq * SettlingTime + 0.5);
    localparam int SettleBits   = (SettleClocks > 0) ? $clog2(SettleClocks + 1) : 1;
    localparam int StartBits    = $clog2(StartTimeout + 1);

    localparam logic [SettleBits-1:0] SettleLoad = SettleBits'(SettleClocks);
    localparam logic [SettleBits-1:0] SettleOne  = SettleBits'(1);
    localparam logic [StartBits-1:0]  StartLoad  = StartBits'(StartTimeout);
    localparam logic [StartBits-1:0]  StartOne   = StartBits'(1);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_START,
        WAIT_DONE,
        SETTLE
    } state_t;

    state_t                state_reg, state_next;
    logic [ChanBits-1:0]   chan_reg, chan_next;
    logic [DataWidth-1:0]  din_reg, din_next;
    logic                  trig_reg, trig_next;
    logic [StartBits-1:0]  start_cnt_reg, start_cnt_next;
    logic [SettleBits-1:0] settle_cnt_reg, settle_cnt_next;
    logic                  err_reg, err_next;
    logic                  ready_int;
    logic                  accept;
    logic                  settle_done;

    // A transfer still in the driver (e.g. one started before reset) blocks new requests.
    assign ready_int = (state_reg == IDLE) && !bus.drv_busy;
    assign accept    = ready_int && bus.req_valid;

    assign bus.req_ready   = ready_int;
    assign bus.drv_trigger = trig_reg;
    assign bus.drv_channel = chan_reg;
    assign bus.drv_din     = din_reg;
    assign busy            = (state_reg != IDLE);
    assign timeout_err     = err_reg;

    // State and datapath registers; reset abandons any in-flight sequence.
    always_ff @(posedge clk_50MHZ or posedge clear) begin
        if (clear) begin
            state_reg      <= IDLE;
            chan_reg       <= '0;
            din_reg        <= '0;
            trig_reg       <= 1'b0;
            start_cnt_reg  <= '0;
            settle_cnt_reg <= '0;
            err_reg        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            chan_reg       <= chan_next;
            din_reg        <= din_next;
            trig_reg       <= trig_next;
            start_cnt_reg  <= start_cnt_next;
            settle_cnt_reg <= settle_cnt_next;
            err_reg        <= err_next;
        end
    end

    // Next-state logic: issue, wait for the driver to start and finish, then settle.
    always_comb begin
        state_next      = state_reg;
        chan_next       = chan_reg;
        din_next        = din_reg;
        trig_next       = 1'b0;
        start_cnt_next  = start_cnt_reg;
        settle_cnt_next = settle_cnt_reg;
        err_next        = err_reg;
        settle_done     = 1'b0;

        // A timeout raised below overrides a coincident clear.
        if (err_clear) begin
            err_next = 1'b0;
        end

        case (state_reg)
            IDLE: begin
                if (accept) begin
                    chan_next  = bus.req_channel;
                    din_next   = bus.req_data;
                    trig_next  = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                start_cnt_next = StartLoad;
                state_next     = WAIT_START;
            end
            WAIT_START: begin
                if (bus.drv_busy) begin
                    state_next = WAIT_DONE;
                end else if (start_cnt_reg <= StartOne) begin
                    start_cnt_next = '0;
                    err_next       = 1'b1;
                    state_next     = IDLE;
                end else begin
                    start_cnt_next = start_cnt_reg - StartOne;
                end
            end
            WAIT_DONE: begin
                if (!bus.drv_busy) begin
                    if (SettleClocks == 0) begin
                        settle_done = 1'b1;
                        state_next  = IDLE;
                    end else begin
                        settle_cnt_next = SettleLoad;
                        state_next      = SETTLE;
                    end
                end
            end
            SETTLE: begin
                if (settle_cnt_reg <= SettleOne) begin
                    settle_cnt_next = '0;
                    settle_done     = 1'b1;
                    state_next      = IDLE;
                end else begin
                    settle_cnt_next = settle_cnt_reg - SettleOne;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    for (genvar gi = 0; gi < NumChannels; gi++) begin : g_chan
        logic flag_reg;

        // Per-channel flag: dropped when a write to this channel is accepted, raised when it has settled.
        always_ff @(posedge clk_50MHZ or posedge clear) begin
            if (clear) begin
                flag_reg <= 1'b0;
            end else if (accept && (bus.req_channel == ChanBits'(gi))) begin
                flag_reg <= 1'b0;
            end else if (settle_done && (chan_reg == ChanBits'(gi))) begin
                flag_reg <= 1'b1;
            end
        end

        assign settled[gi] = flag_reg;
    end
endmodule

// File: tb/tb_dac_settle_sequencer.sv
// Randomised scoreboard bench for dac_settle_sequencer with a behavioural DAC driver model.
module tb_dac_settle_sequencer;
    localparam int T = 8;     // start timeout in clocks
    localparam int S = 225;   // settling clocks at 50 MHz / 4.5 us

    logic clk_50MHZ = 1'b0;
    logic clear     = 1'b1;
    always #10 clk_50MHZ = ~clk_50MHZ;

    int cyc = 0;
    always @(posedge clk_50MHZ) cyc <= cyc + 1;

    dac_settle_sequencer_if #(.ChanBits(1), .DataWidth(10)) bus ();
    dac_settle_sequencer_if #(.ChanBits(2), .DataWidth(12)) bus2 ();

    logic       busy, timeout_err, err_clear;
    logic [1:0] settled;
    logic       busy2, timeout_err2, err_clear2;
    logic [3:0] settled2;
    logic       drv_busy_model, force_busy;

    assign bus.drv_busy = drv_busy_model | force_busy;

    dac_settle_sequencer dut (
        .clk_50MHZ   (clk_50MHZ),
        .clear       (clear),
        .bus         (bus),
        .busy        (busy),
        .settled     (settled),
        .timeout_err (timeout_err),
        .err_clear   (err_clear)
    );

    dac_settle_sequencer #(
        .NumChannels  (4),
        .DataWidth    (12),
        .SettlingTime (0.0)
    ) dut2 (
        .clk_50MHZ   (clk_50MHZ),
        .clear       (clear),
        .bus         (bus2),
        .busy        (busy2),
        .settled     (settled2),
        .timeout_err (timeout_err2),
        .err_clear   (err_clear2)
    );

    typedef struct { int ch; int data; int cyc; int pre; } trig_t;
    typedef struct { int cyc; int post; int err; int ch; int data; } done_t;
    typedef struct { int d; int b; bit nores; } drv_t;

    trig_t trig_q[$];
    done_t done_q[$];
    drv_t  drv_q[$];

    int total = 0;
    int bad   = 0;
    int model_settled, model_err, last_done;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name, input string what);
        total++;
        bad++;
        $display("FAIL %s: %s (cyc %0d)", name, what, cyc);
    endtask

    // Driver model: busy rises d+1 cycles after the trigger is seen and lasts b cycles.
    initial begin : driver
        drv_t p;
        drv_busy_model = 1'b0;
        forever begin
            @(negedge clk_50MHZ);
            if (!clear && bus.drv_trigger && drv_q.size() > 0) begin
                p = drv_q.pop_front();
                if (!p.nores) begin
                    repeat (1 + p.d) @(negedge clk_50MHZ);
                    drv_busy_model = 1'b1;
                    repeat (p.b) @(negedge clk_50MHZ);
                    drv_busy_model = 1'b0;
                end
            end
        end
    end

    // Monitor: pops expectations when the DUT triggers the driver or finishes a sequence.
    initial begin : monitor
        trig_t t;
        done_t dn;
        logic  prev_trig, prev_busy;
        prev_trig = 1'b0;
        prev_busy = 1'b0;
        forever begin
            @(negedge clk_50MHZ);
            #1;
            if (clear) begin
                prev_trig = 1'b0;
                prev_busy = 1'b0;
            end else begin
                if (prev_trig) chk("trig_width", bus.drv_trigger, 0);
                if (bus.drv_trigger) begin
                    if (trig_q.size() == 0) begin
                        fail("unexpected_trig", "drv_trigger=1 required 0 (no request pending)");
                    end else begin
                        t = trig_q.pop_front();
                        chk("trig_cyc", cyc, t.cyc);
                        chk("drv_channel", bus.drv_channel, t.ch);
                        chk("drv_din", bus.drv_din, t.data);
                        chk("settled_on_accept", settled, t.pre);
                    end
                end
                if (prev_busy && !busy) begin
                    if (done_q.size() == 0) begin
                        fail("unexpected_done", "busy fell required high (no sequence pending)");
                    end else begin
                        dn = done_q.pop_front();
                        chk("done_cyc", cyc, dn.cyc);
                        chk("settled_done", settled, dn.post);
                        chk("timeout_err", timeout_err, dn.err);
                        chk("hold_channel", bus.drv_channel, dn.ch);
                        chk("hold_din", bus.drv_din, dn.data);
                    end
                end
                chk("req_ready", bus.req_ready, !busy && !bus.drv_busy);
                prev_trig = bus.drv_trigger;
                prev_busy = busy;
            end
        end
    end

    task automatic issue(input int ch, input int data, input int d, input int b, input bit nores,
                         input bit hold, input bit keep_valid, input bit track_done, output int a);
        trig_t t;
        done_t dn;
        drv_t  p;
        int    waited;
        int    pre;
        a = -1;
        @(negedge clk_50MHZ);
        #2;
        bus.req_valid   = 1'b1;
        bus.req_channel = 1'(ch);
        bus.req_data    = 10'(data);
        if (hold) err_clear = 1'b1;
        waited = 0;
        while (!bus.req_ready && waited < 2000) begin
            @(negedge clk_50MHZ);
            #2;
            waited++;
        end
        if (!bus.req_ready) begin
            fail("accept_wait", "req_ready=0 required 1 within 2000 cycles");
            bus.req_valid = 1'b0;
            return;
        end
        a   = cyc + 1;
        pre = model_settled & ~(1 << ch);
        p.d = d; p.b = b; p.nores = nores;
        drv_q.push_back(p);
        t.ch = ch; t.data = data; t.cyc = a; t.pre = pre;
        trig_q.push_back(t);
        if (track_done) begin
            dn.cyc  = nores ? (a + 1 + T) : (a + 2 + d + b + S);
            dn.post = nores ? pre : (pre | (1 << ch));
            dn.err  = nores ? 1 : (hold ? 0 : model_err);
            dn.ch   = ch;
            dn.data = data;
            done_q.push_back(dn);
            model_settled = dn.post;
            model_err     = dn.err;
            last_done     = dn.cyc;
        end
        $display("txn ch=%0d data=%03h start_lat=%0d busy_len=%0d no_start=%0d hold_clr=%0d accept_cyc=%0d",
                 ch, data, d, b, nores, hold, a);
        @(posedge clk_50MHZ);
        #1;
        if (!keep_valid) bus.req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk_50MHZ);
            #2;
            n++;
        end while (busy && n < 5000);
        if (busy) fail("idle_wait", "busy=1 required 0 within 5000 cycles");
        err_clear = 1'b0;
    endtask

    task automatic pulse_err_clear();
        @(negedge clk_50MHZ);
        #2;
        err_clear = 1'b1;
        @(negedge clk_50MHZ);
        #2;
        err_clear = 1'b0;
        chk("err_clear", timeout_err, 0);
        model_err = 0;
    endtask

    initial begin : watchdog
        #1_800_000;
        $display("FAIL watchdog: simulation still running at cyc %0d, required finish earlier", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int a, ch, data, d, b, waited, prev_a;
        bit nores, hold;
        int codes[3];
        codes = '{0, 512, 1023};

        bus.req_valid = 1'b0; bus.req_channel = '0; bus.req_data = '0;
        bus2.req_valid = 1'b0; bus2.req_channel = '0; bus2.req_data = '0; bus2.drv_busy = 1'b0;
        err_clear = 1'b0; err_clear2 = 1'b0; force_busy = 1'b0;
        model_settled = 0; model_err = 0; last_done = 0;

        // Reset state
        repeat (3) @(negedge clk_50MHZ);
        #2;
        chk("rst_trig", bus.drv_trigger, 0);
        chk("rst_chan", bus.drv_channel, 0);
        chk("rst_din", bus.drv_din, 0);
        chk("rst_settled", settled, 0);
        chk("rst_err", timeout_err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", bus.req_ready, 1);
        chk("rst_settled2", settled2, 0);
        clear = 1'b0;

        // Directed opening transactions followed by random ones
        for (int i = 0; i < 15; i++) begin
            ch    = $urandom_range(0, 1);
            data  = $urandom_range(0, 1023);
            d     = $urandom_range(0, T - 1);
            b     = $urandom_range(1, 40);
            nores = ($urandom_range(0, 4) == 0);
            hold  = ($urandom_range(0, 3) == 0);
            case (i)
                0: begin ch = 0; data = 'h155; d = 0; b = 34; nores = 0; hold = 0; end
                1: begin ch = 1; nores = 0; hold = 0; end
                2: begin ch = 0; nores = 0; hold = 0; end
                3: begin ch = 1; nores = 1; hold = 0; end
                4: begin nores = 1; hold = 1; end
                default: ;
            endcase
            issue(ch, data, d, b, nores, hold, 1'b0, 1'b1, a);
            wait_idle();
            if (i == 3 || $urandom_range(0, 3) == 0) pulse_err_clear();
        end

        // Back-to-back requests with req_valid held high
        for (int k = 0; k < 3; k++) begin
            prev_a = last_done;
            issue(k % 2, codes[k], $urandom_range(0, T - 1), $urandom_range(1, 40), 1'b0, 1'b0,
                  (k < 2), 1'b1, a);
            if (k > 0) chk("b2b_accept_cyc", a, prev_a + 1);
        end
        wait_idle();

        // Reset in the middle of the settling interval, with the driver still busy
        issue(1, 'h2AA, 0, 10, 1'b0, 1'b0, 1'b0, 1'b0, a);
        do begin
            @(negedge clk_50MHZ);
            #2;
        end while (cyc < a + 2 + 10 + 100);
        chk("busy_in_settle", busy, 1);
        bus.req_valid   = 1'b1;
        bus.req_channel = 1'b0;
        force_busy      = 1'b1;
        clear           = 1'b1;
        #1;
        chk("clr_settled", settled, 0);
        chk("clr_busy", busy, 0);
        chk("clr_trig", bus.drv_trigger, 0);
        chk("clr_ready", bus.req_ready, 0);
        chk("clr_err", timeout_err, 0);
        @(negedge clk_50MHZ);
        #2;
        clear = 1'b0;
        repeat (3) begin
            @(negedge clk_50MHZ);
            #2;
            chk("ready_while_drv_busy", bus.req_ready, 0);
            chk("no_accept_while_drv_busy", busy, 0);
        end
        bus.req_valid = 1'b0;
        force_busy    = 1'b0;
        #1;
        chk("ready_after_drv_idle", bus.req_ready, 1);
        model_settled = 0;
        model_err     = 0;

        // Four-channel, 12-bit instance with zero settling time
        @(negedge clk_50MHZ);
        #2;
        bus2.req_valid   = 1'b1;
        bus2.req_channel = 2'd3;
        bus2.req_data    = 12'hABC;
        waited = 0;
        while (!bus2.req_ready && waited < 100) begin
            @(negedge clk_50MHZ);
            #2;
            waited++;
        end
        if (!bus2.req_ready) fail("d2_accept_wait", "req_ready=0 required 1 within 100 cycles");
        a = cyc + 1;
        $display("txn dut2 ch=3 data=abc start_lat=0 busy_len=5 accept_cyc=%0d", a);
        @(posedge clk_50MHZ);
        #1;
        bus2.req_valid = 1'b0;
        @(negedge clk_50MHZ);
        #2;
        chk("d2_trig", bus2.drv_trigger, 1);
        chk("d2_chan", bus2.drv_channel, 3);
        chk("d2_din", bus2.drv_din, 'hABC);
        @(negedge clk_50MHZ);
        #2;
        bus2.drv_busy = 1'b1;
        repeat (5) @(negedge clk_50MHZ);
        #2;
        bus2.drv_busy = 1'b0;
        chk("d2_settled_early", settled2, 0);
        @(negedge clk_50MHZ);
        #2;
        chk("d2_done_cyc", cyc, a + 7);
        chk("d2_settled", settled2, 4'b1000);
        chk("d2_busy", busy2, 0);
        chk("d2_err", timeout_err2, 0);

        repeat (5) @(negedge clk_50MHZ);
        #2;
        chk("trig_q_drained", trig_q.size(), 0);
        chk("done_q_drained", done_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
